collision_arbiter: RTL and testbench
====================================

// Module: collision_arbiter
// PURPOSE
// Serialises ball collision events into one registered, edge-tagged grant per frame for the ball
// controller. Sits between the collision detectors (frame, obstacle, spring, flipper, bumper) and
// the ball speed/position logic. Enforces fixed priority, per-source cooldown in frames, and a
// valid/ack handshake. Counts lost events for debug.
// PARAMETERS
// NUM_SRC          5   number of collision sources; index 0 = highest priority (0 frame,1 obstacle,2 spring,3 flipper,4 bumper)
// COOLDOWN_FRAMES  2   frames a source stays masked after an acked grant; range 0..15
// PORTS
// clk             in   1        system clock
// reset           in   1        asynchronous, active-high reset
// startOfFrame    in   1        one-cycle pulse at each frame start
// pause           in   1        freezes arbitration and cooldowns
// reset_level     in   1        synchronous clear, same effect as reset
// collisionReq    in   NUM_SRC  level collision requests, one bit per source
// hitEdgeCode     in   4        {Left,Top,Right,Bottom} edge code of the current collision
// grantAck        in   1        ball controller consumed the grant
// grantValid      out  1        grant presented
// grantOneHot     out  NUM_SRC  winning source, one-hot; 0 when grantValid=0
// grantEdgeCode   out  4        hitEdgeCode latched at grant time
// cooldownActive  out  NUM_SRC  bit set while the source is masked
// droppedCount    out  8        saturating count of lost collision events
// BEHAVIOUR
// - Reset or reset_level: state=IDLE. grantValid=0. grantOneHot=0. grantEdgeCode=0.
//   All cooldown counters=0, so cooldownActive=0. droppedCount=0. Request edge registers=0.
// - eligible = collisionReq & ~cooldownActive. Winner = lowest set index of eligible.
// - FSM states: IDLE, PRESENT, DONE.
//   - IDLE with eligible!=0: latch winner and hitEdgeCode, go to PRESENT.
//     grantValid=1 on the cycle after the sampling edge (1-cycle latency).
//   - PRESENT: outputs held stable until grantAck=1.
//     On ack, load the winner's cooldown with COOLDOWN_FRAMES, deassert grantValid next cycle,
//     and go to DONE.
//   - PRESENT, startOfFrame without ack: abandon the grant. Go to IDLE, load no cooldown,
//     droppedCount+1.
//   - PRESENT, ack and startOfFrame together: ack wins. Cooldown loaded (no decrement that cycle).
//     Go straight to IDLE.
//   - DONE: no new grants. startOfFrame returns to IDLE. This gives at most one grant per frame.
// - Cooldown counters are 4 bits per source. On startOfFrame, each nonzero counter decrements
//   unless it is being loaded in the same cycle. cooldownActive[i] = (cnt[i]!=0).
//   COOLDOWN_FRAMES=0 means no masking.
// - Dropped events: a rising edge of collisionReq[i] on a non-cooled source is lost in three cases:
//   - it arrives in PRESENT or DONE;
//   - it is a loser in IDLE arbitration;
//   - it arrives during pause.
//   Each cycle, add the popcount of lost edges. Saturate at 255.
//   Edges on cooled-down sources are ignored and not counted.
// - pause=1:
//   - state, latched grant and cooldowns frozen;
//   - grantValid forced 0 and grantAck ignored;
//   - startOfFrame ignored.
//   On unpause, a held PRESENT grant reappears with the same source and edge code.
// - grantAck outside PRESENT is ignored.
// - reset or reset_level asserted in PRESENT: grant discarded, no cooldown loaded, no drop counted.
// - The request edge register updates every cycle, including during pause.
// TESTING
// - Single request: collisionReq=00100, hitEdgeCode=0001 in IDLE -> next cycle grantValid=1,
//   grantOneHot=00100, grantEdgeCode=0001. Ack -> grantValid=0, cooldownActive[2]=1 for 2 frames.
// - Simultaneous rising edges: 10011 -> grantOneHot=00001, droppedCount=2. A second grant waits
//   for startOfFrame and DONE->IDLE.
// - Cooldown: source 4 acked. Re-request at frames +1 and +2 -> no grant, no drop.
//   After the 2nd startOfFrame -> grant is issued.
// - No ack: grant presented and startOfFrame arrives without ack -> grantValid=0, droppedCount+1,
//   cooldownActive unchanged.
// - Ack with startOfFrame on the same cycle -> state IDLE, cooldown=COOLDOWN_FRAMES, no decrement
//   that cycle.
// - Pause in PRESENT -> grantValid=0 while paused, cooldown counts held. Unpause -> same grant
//   returns. reset mid-PRESENT -> all outputs 0.

Source files
------------

// File: rtl/collision_arbiter.sv
// Fixed-priority collision arbiter: one edge-tagged grant per frame, per-source
// cooldown in frames, valid/ack handshake and a saturating lost-event counter.
module collision_arbiter #(
  parameter int NUM_SRC         = 5,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               pause,
  input  logic               reset_level,
  input  logic [NUM_SRC-1:0] collisionReq,
  input  logic [3:0]         hitEdgeCode,
  input  logic               grantAck,
  output logic               grantValid,
  output logic [NUM_SRC-1:0] grantOneHot,
  output logic [3:0]         grantEdgeCode,
  output logic [NUM_SRC-1:0] cooldownActive,
  output logic [7:0]         droppedCount
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_DONE} state_t;

  localparam logic [3:0] CD_LOAD = 4'(COOLDOWN_FRAMES);

  state_t             r_state;
  state_t             w_next_state;
  logic [NUM_SRC-1:0] r_req_d;
  logic [NUM_SRC-1:0] r_grant_src;
  logic [3:0]         r_edge;
  logic [3:0]         r_cnt [NUM_SRC];
  logic [7:0]         r_dropped;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_rise_nc;
  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_winner;
  logic [NUM_SRC-1:0] w_lost;
  logic               w_take;
  logic               w_ack;
  logic               w_abandon;
  logic               w_sof;
  logic [7:0]         w_drop_inc;

  function automatic logic [NUM_SRC-1:0] lowest_one(input logic [NUM_SRC-1:0] v);
    logic [NUM_SRC-1:0] r;
    logic               found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] popcount(input logic [NUM_SRC-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < NUM_SRC; i++) c = c + 8'(v[i]);
    return c;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Arbitration and event decode; everything qualified by pause is frozen while paused.
  always_comb begin
    w_rise     = collisionReq & ~r_req_d;
    w_rise_nc  = w_rise & ~cooldownActive;
    w_eligible = collisionReq & ~cooldownActive;
    w_winner   = lowest_one(w_eligible);
    w_take     = !pause && (r_state == S_IDLE) && (|w_eligible);
    w_ack      = !pause && (r_state == S_PRESENT) && grantAck;
    w_abandon  = !pause && (r_state == S_PRESENT) && startOfFrame && !grantAck;
    w_sof      = !pause && startOfFrame;
  end

  always_comb begin
    w_lost = w_rise_nc;
    if (!pause && r_state == S_IDLE) w_lost = w_rise_nc & ~w_winner;
    w_drop_inc = popcount(w_lost) + 8'(w_abandon);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else if (reset_level) r_state <= S_IDLE;
    else r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!pause) begin
      unique case (r_state)
        S_IDLE:    if (|w_eligible) w_next_state = S_PRESENT;
        S_PRESENT: begin
          if (grantAck) w_next_state = startOfFrame ? S_IDLE : S_DONE;
          else if (startOfFrame) w_next_state = S_IDLE;
        end
        S_DONE:    if (startOfFrame) w_next_state = S_IDLE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    grantValid    = (r_state == S_PRESENT) && !pause;
    grantOneHot   = grantValid ? r_grant_src : '0;
    grantEdgeCode = r_edge;
    droppedCount  = r_dropped;
    for (int i = 0; i < NUM_SRC; i++) cooldownActive[i] = (r_cnt[i] != 4'd0);
  end

  // Edge history tracks requests every cycle, pause included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_req_d <= '0;
    else if (reset_level) r_req_d <= '0;
    else r_req_d <= collisionReq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant_src <= '0;
      r_edge      <= '0;
    end else if (reset_level) begin
      r_grant_src <= '0;
      r_edge      <= '0;
    end else if (w_take) begin
      r_grant_src <= w_winner;
      r_edge      <= hitEdgeCode;
    end
  end

  // A load on ack takes precedence over the frame decrement in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= '0;
    end else if (reset_level) begin
      for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_ack && r_grant_src[i]) r_cnt[i] <= CD_LOAD;
        else if (w_sof && r_cnt[i] != 4'd0) r_cnt[i] <= r_cnt[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_dropped <= '0;
    else if (reset_level) r_dropped <= '0;
    else r_dropped <= sat_add8(r_dropped, w_drop_inc);
  end

endmodule

// File: tb/tb_collision_arbiter.sv
// Scenario bench for collision_arbiter: expected grants queued when requests are
// driven and compared when grantValid appears.
module tb_collision_arbiter;

  logic       clk;
  logic       reset;
  logic       startOfFrame;
  logic       pause;
  logic       reset_level;
  logic [4:0] collisionReq;
  logic [3:0] hitEdgeCode;
  logic       grantAck;
  logic       grantValid;
  logic [4:0] grantOneHot;
  logic [3:0] grantEdgeCode;
  logic [4:0] cooldownActive;
  logic [7:0] droppedCount;

  typedef struct packed {
    logic [4:0] oh;
    logic [3:0] ec;
  } grant_t;

  grant_t sb_q[$];
  grant_t exp_g;
  int     checks = 0;
  int     errors = 0;

  collision_arbiter #(.NUM_SRC(5), .COOLDOWN_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .pause(pause),
    .reset_level(reset_level), .collisionReq(collisionReq), .hitEdgeCode(hitEdgeCode),
    .grantAck(grantAck), .grantValid(grantValid), .grantOneHot(grantOneHot),
    .grantEdgeCode(grantEdgeCode), .cooldownActive(cooldownActive), .droppedCount(droppedCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; startOfFrame = 0; pause = 0; reset_level = 0;
    collisionReq = '0; hitEdgeCode = '0; grantAck = 0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grantValid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", grantValid); end
    checks++; if (grantOneHot !== 5'b0) begin errors++; $display("FAIL rst_onehot got=%b exp=00000", grantOneHot); end
    checks++; if (grantEdgeCode !== 4'b0) begin errors++; $display("FAIL rst_edge got=%b exp=0000", grantEdgeCode); end
    checks++; if (cooldownActive !== 5'b0) begin errors++; $display("FAIL rst_cool got=%b exp=00000", cooldownActive); end
    checks++; if (droppedCount !== 8'd0) begin errors++; $display("FAIL rst_drop got=%0d exp=0", droppedCount); end
  endtask

  task automatic test_single();
    do_reset();
    collisionReq = 5'b00100; hitEdgeCode = 4'b0001;
    sb_q.push_back('{oh: 5'b00100, ec: 4'b0001});
    step();
    checks++;
    if (grantValid !== 1'b1 || sb_q.size() == 0) begin
      errors++; $display("FAIL single_valid got=%0b exp=1", grantValid);
    end else begin
      exp_g = sb_q.pop_front();
      if ({grantOneHot, grantEdgeCode} !== exp_g) begin
        errors++; $display("FAIL single_grant got=%b/%b exp=%b/%b", grantOneHot, grantEdgeCode, exp_g.oh, exp_g.ec);
      end
    end
    collisionReq = '0; grantAck = 1'b1;
    step();
    grantAck = 1'b0;
    checks++; if (grantValid !== 1'b0) begin errors++; $display("FAIL single_ackvalid got=%0b exp=0", grantValid); end
    checks++; if (cooldownActive !== 5'b00100) begin errors++; $display("FAIL single_cool0 got=%b exp=00100", cooldownActive); end
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    checks++; if (cooldownActive !== 5'b00100) begin errors++; $display("FAIL single_cool1 got=%b exp=00100", cooldownActive); end
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    checks++; if (cooldownActive !== 5'b00000) begin errors++; $display("FAIL single_cool2 got=%b exp=00000", cooldownActive); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    collisionReq = 5'b10011; hitEdgeCode = 4'b0110;
    sb_q.push_back('{oh: 5'b00001, ec: 4'b0110});
    step();
    checks++;
    if (grantValid !== 1'b1 || sb_q.size() == 0) begin
      errors++; $display("FAIL simul_valid got=%0b exp=1", grantValid);
    end else begin
      exp_g = sb_q.pop_front();
      if ({grantOneHot, grantEdgeCode} !== exp_g) begin
        errors++; $display("FAIL simul_grant got=%b/%b exp=%b/%b", grantOneHot, grantEdgeCode, exp_g.oh, exp_g.ec);
      end
    end
    checks++; if (droppedCount !== 8'd2) begin errors++; $display("FAIL simul_drop got=%0d exp=2", droppedCount); end
    grantAck = 1'b1; step(); grantAck = 1'b0;
    step(); step();
    checks++; if (grantValid !== 1'b0) begin errors++; $display("FAIL simul_done_valid got=%0b exp=0", grantValid); end
    hitEdgeCode = 4'b1001;
    sb_q.push_back('{oh: 5'b00010, ec: 4'b1001});
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    checks++; if (grantValid !== 1'b0) begin errors++; $display("FAIL simul_sof_valid got=%0b exp=0", grantValid); end
    step();
    checks++;
    if (grantValid !== 1'b1 || sb_q.size() == 0) begin
      errors++; $display("FAIL simul_second_valid got=%0b exp=1", grantValid);
    end else begin
      exp_g = sb_q.pop_front();
      if ({grantOneHot, grantEdgeCode} !== exp_g) begin
        errors++; $display("FAIL simul_second got=%b/%b exp=%b/%b", grantOneHot, grantEdgeCode, exp_g.oh, exp_g.ec);
      end
    end
    checks++; if (droppedCount !== 8'd2) begin errors++; $display("FAIL simul_drop2 got=%0d exp=2", droppedCount); end
  endtask

  task automatic test_cooldown();
    do_reset();
    collisionReq = 5'b10000; hitEdgeCode = 4'b1000;
    sb_q.push_back('{oh: 5'b10000, ec: 4'b1000});
    step();
    checks++;
    if (grantValid !== 1'b1 || sb_q.size() == 0) begin
      errors++; $display("FAIL cool_valid got=%0b exp=1", grantValid);
    end else begin
      exp_g = sb_q.pop_front();
      if ({grantOneHot, grantEdgeCode} !== exp_g) begin
        errors++; $display("FAIL cool_grant got=%b/%b exp=%b/%b", grantOneHot, grantEdgeCode, exp_g.oh, exp_g.ec);
      end
    end
    collisionReq = '0; grantAck = 1'b1; step(); grantAck = 1'b0;
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    collisionReq = 5'b10000; hitEdgeCode = 4'b0011;
    step();
    checks++; if (grantValid !== 1'b0) begin errors++; $display("FAIL cool_f1_valid got=%0b exp=0", grantValid); end
    checks++; if (droppedCount !== 8'd0) begin errors++; $display("FAIL cool_f1_drop got=%0d exp=0", droppedCount); end
    sb_q.push_back('{oh: 5'b10000, ec: 4'b0011});
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    checks++; if (grantValid !== 1'b0) begin errors++; $display("FAIL cool_f2_valid got=%0b exp=0", grantValid); end
    checks++; if (cooldownActive !== 5'b0) begin errors++; $display("FAIL cool_f2_cool got=%b exp=00000", cooldownActive); end
    step();
    checks++;
    if (grantValid !== 1'b1 || sb_q.size() == 0) begin
      errors++; $display("FAIL cool_regrant_valid got=%0b exp=1", grantValid);
    end else begin
      exp_g = sb_q.pop_front();
      if ({grantOneHot, grantEdgeCode} !== exp_g) begin
        errors++; $display("FAIL cool_regrant got=%b/%b exp=%b/%b", grantOneHot, grantEdgeCode, exp_g.oh, exp_g.ec);
      end
    end
    checks++; if (droppedCount !== 8'd0) begin errors++; $display("FAIL cool_drop got=%0d exp=0", droppedCount); end
  endtask

  task automatic test_no_ack();
    do_reset();
    collisionReq = 5'b01000; hitEdgeCode = 4'b0100;
    sb_q.push_back('{oh: 5'b01000, ec: 4'b0100});
    step();
    checks++;
    if (grantValid !== 1'b1 || sb_q.size() == 0) begin
      errors++; $display("FAIL noack_valid got=%0b exp=1", grantValid);
    end else begin
      exp_g = sb_q.pop_front();
      if ({grantOneHot, grantEdgeCode} !== exp_g) begin
        errors++; $display("FAIL noack_grant got=%b/%b exp=%b/%b", grantOneHot, grantEdgeCode, exp_g.oh, exp_g.ec);
      end
    end
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    collisionReq = '0;
    checks++; if (grantValid !== 1'b0) begin errors++; $display("FAIL noack_after got=%0b exp=0", grantValid); end
    checks++; if (droppedCount !== 8'd1) begin errors++; $display("FAIL noack_drop got=%0d exp=1", droppedCount); end
    checks++; if (cooldownActive !== 5'b0) begin errors++; $display("FAIL noack_cool got=%b exp=00000", cooldownActive); end
    reset_level = 1'b1; step(); reset_level = 1'b0;
    checks++; if (droppedCount !== 8'd0) begin errors++; $display("FAIL lvlclr_drop got=%0d exp=0", droppedCount); end
  endtask

  task automatic test_ack_sof();
    do_reset();
    collisionReq = 5'b00010; hitEdgeCode = 4'b0010;
    sb_q.push_back('{oh: 5'b00010, ec: 4'b0010});
    step();
    checks++;
    if (grantValid !== 1'b1 || sb_q.size() == 0) begin
      errors++; $display("FAIL acksof_valid got=%0b exp=1", grantValid);
    end else begin
      exp_g = sb_q.pop_front();
      if ({grantOneHot, grantEdgeCode} !== exp_g) begin
        errors++; $display("FAIL acksof_grant got=%b/%b exp=%b/%b", grantOneHot, grantEdgeCode, exp_g.oh, exp_g.ec);
      end
    end
    collisionReq = '0; grantAck = 1'b1; startOfFrame = 1'b1;
    step();
    grantAck = 1'b0; startOfFrame = 1'b0;
    checks++; if (grantValid !== 1'b0) begin errors++; $display("FAIL acksof_after got=%0b exp=0", grantValid); end
    checks++; if (cooldownActive !== 5'b00010) begin errors++; $display("FAIL acksof_cool0 got=%b exp=00010", cooldownActive); end
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    checks++; if (cooldownActive !== 5'b00010) begin errors++; $display("FAIL acksof_cool1 got=%b exp=00010", cooldownActive); end
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    checks++; if (cooldownActive !== 5'b00000) begin errors++; $display("FAIL acksof_cool2 got=%b exp=00000", cooldownActive); end
  endtask

  task automatic test_pause();
    do_reset();
    collisionReq = 5'b00001; hitEdgeCode = 4'b1010;
    sb_q.push_back('{oh: 5'b00001, ec: 4'b1010});
    step();
    checks++;
    if (grantValid !== 1'b1 || sb_q.size() == 0) begin
      errors++; $display("FAIL pause_first_valid got=%0b exp=1", grantValid);
    end else begin
      exp_g = sb_q.pop_front();
      if ({grantOneHot, grantEdgeCode} !== exp_g) begin
        errors++; $display("FAIL pause_first got=%b/%b exp=%b/%b", grantOneHot, grantEdgeCode, exp_g.oh, exp_g.ec);
      end
    end
    pause = 1'b1; #1;
    checks++; if (grantValid !== 1'b0 || grantOneHot !== 5'b0) begin errors++; $display("FAIL pause_hidden got=%0b/%b exp=0/00000", grantValid, grantOneHot); end
    grantAck = 1'b1; startOfFrame = 1'b1; collisionReq = 5'b00101;
    step();
    grantAck = 1'b0; startOfFrame = 1'b0;
    step();
    checks++; if (droppedCount !== 8'd1) begin errors++; $display("FAIL pause_drop got=%0d exp=1", droppedCount); end
    checks++; if (cooldownActive !== 5'b0) begin errors++; $display("FAIL pause_cool got=%b exp=00000", cooldownActive); end
    sb_q.push_back('{oh: 5'b00001, ec: 4'b1010});
    pause = 1'b0; #1;
    checks++;
    if (grantValid !== 1'b1 || sb_q.size() == 0) begin
      errors++; $display("FAIL pause_return_valid got=%0b exp=1", grantValid);
    end else begin
      exp_g = sb_q.pop_front();
      if ({grantOneHot, grantEdgeCode} !== exp_g) begin
        errors++; $display("FAIL pause_return got=%b/%b exp=%b/%b", grantOneHot, grantEdgeCode, exp_g.oh, exp_g.ec);
      end
    end
    reset = 1'b1; #1;
    checks++;
    if ({grantValid, grantOneHot, grantEdgeCode, cooldownActive, droppedCount} !== 23'b0) begin
      errors++; $display("FAIL midreset got=%0b/%b/%b/%b/%0d exp=all zero", grantValid, grantOneHot, grantEdgeCode, cooldownActive, droppedCount);
    end
    collisionReq = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      collisionReq = 5'b11111; step();
      collisionReq = 5'b00000; step();
    end
    checks++; if (droppedCount !== 8'd50) begin errors++; $display("FAIL sat_mid got=%0d exp=50", droppedCount); end
    for (int k = 0; k < 50; k++) begin
      collisionReq = 5'b11111; step();
      collisionReq = 5'b00000; step();
    end
    checks++; if (droppedCount !== 8'd255) begin errors++; $display("FAIL sat_top got=%0d exp=255", droppedCount); end
    pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_cooldown();
    test_no_ack();
    test_ack_sof();
    test_pause();
    test_saturate();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
